// File: rtl/din_debouncer.sv
// rtl/din_debouncer.sv - two-flop synchronized, counter-qualified switch debouncer
// with registered level output and one-cycle rise/fall pulses.
module din_debouncer #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  input  logic en,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam logic [1:0] IDLE_LO = 2'd0;
  localparam logic [1:0] CHK_HI  = 2'd1;
  localparam logic [1:0] IDLE_HI = 2'd2;
  localparam logic [1:0] CHK_LO  = 2'd3;

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  logic       s1;
  logic       s2;
  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [7:0] cnt;
  logic [7:0] cnt_nxt;
  logic [7:0] cnt_inc;
  logic       dout_nxt;
  logic       rise_nxt;
  logic       fall_nxt;

  // Synchronizer runs every cycle; en only gates the qualification logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  assign cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dout_nxt  = dout;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    if (en) begin
      case (state)
        IDLE_LO: begin
          if (s2) begin
            if (STABLE == 8'd1) begin
              state_nxt = IDLE_HI;
              cnt_nxt   = 8'd0;
              dout_nxt  = 1'b1;
              rise_nxt  = 1'b1;
            end else begin
              state_nxt = CHK_HI;
              cnt_nxt   = 8'd1;
            end
          end
        end
        CHK_HI: begin
          if (s2) begin
            if (cnt_inc == STABLE) begin
              state_nxt = IDLE_HI;
              cnt_nxt   = 8'd0;
              dout_nxt  = 1'b1;
              rise_nxt  = 1'b1;
            end else begin
              cnt_nxt = cnt_inc;
            end
          end else begin
            state_nxt = IDLE_LO;
            cnt_nxt   = 8'd0;
          end
        end
        IDLE_HI: begin
          if (!s2) begin
            if (STABLE == 8'd1) begin
              state_nxt = IDLE_LO;
              cnt_nxt   = 8'd0;
              dout_nxt  = 1'b0;
              fall_nxt  = 1'b1;
            end else begin
              state_nxt = CHK_LO;
              cnt_nxt   = 8'd1;
            end
          end
        end
        default: begin
          if (!s2) begin
            if (cnt_inc == STABLE) begin
              state_nxt = IDLE_LO;
              cnt_nxt   = 8'd0;
              dout_nxt  = 1'b0;
              fall_nxt  = 1'b1;
            end else begin
              cnt_nxt = cnt_inc;
            end
          end else begin
            state_nxt = IDLE_HI;
            cnt_nxt   = 8'd0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE_LO;
      cnt   <= 8'd0;
      dout  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      dout  <= dout_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
    end
  end

  assign busy = (state == CHK_HI) || (state == CHK_LO);

endmodule

// File: tb/tb_din_debouncer.sv
// tb/tb_din_debouncer.sv - checks din_debouncer against a run-length model of
// the accepted level, with directed timing scenarios and randomized bounce.
module tb_din_debouncer;
  localparam int SC = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic din;
  logic en;
  logic dout;
  logic rise;
  logic fall;
  logic busy;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: din delayed two samples, and the length of the current run of
  // enabled edges on which that delayed value disagreed with the accepted level.
  logic q1 = 1'b0;
  logic q2 = 1'b0;
  logic lvl = 1'b0;
  logic m_rise = 1'b0;
  logic m_fall = 1'b0;
  int   run = 0;

  din_debouncer #(.STABLE_CYCLES(SC)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (din),
    .en   (en),
    .dout (dout),
    .rise (rise),
    .fall (fall),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q1 = 1'b0; q2 = 1'b0; lvl = 1'b0; run = 0; m_rise = 1'b0; m_fall = 1'b0;
      end else begin
        logic seen;
        seen   = q2;
        q2     = q1;
        q1     = din;
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (en) begin
          if (seen != lvl) begin
            run++;
            if (run >= SC) begin
              lvl = seen;
              run = 0;
              if (lvl) m_rise = 1'b1;
              else     m_fall = 1'b1;
            end
          end else begin
            run = 0;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("model_dout", dout, lvl);
      chk("model_rise", rise, m_rise);
      chk("model_fall", fall, m_fall);
      chk("model_busy", busy, run > 0);
      chk("rise_fall_exclusive", rise & fall, 0);
    end
  end

  initial begin
    int e;
    int hold;
    rst_n = 1'b0; din = 1'b0; en = 1'b1;
    #1;
    chk("reset_dout", dout, 0);
    chk("reset_rise", rise, 0);
    chk("reset_fall", fall, 0);
    chk("reset_busy", busy, 0);
    #1 rst_n = 1'b1;

    // Clean rise: din up at 12 ns, edges at 15, 25, ...
    #10 din = 1'b1;
    #18 chk("clean_busy_30", busy, 0);
    #10 chk("clean_busy_40", busy, 1);
    #20 chk("clean_dout_60", dout, 0);
    chk("clean_busy_60", busy, 1);
    #10 chk("clean_dout_70", dout, 1);
    chk("clean_rise_70", rise, 1);
    chk("clean_busy_70", busy, 0);
    #10 chk("clean_rise_80", rise, 0);
    chk("clean_dout_80", dout, 1);

    // Falling path
    #2 din = 1'b0;
    #48 chk("fall_dout_130", dout, 1);
    chk("fall_fall_130", fall, 0);
    #10 chk("fall_dout_140", dout, 0);
    chk("fall_fall_140", fall, 1);
    chk("fall_rise_140", rise, 0);
    #10 chk("fall_fall_150", fall, 0);

    // Glitch of two cycles
    #2 din = 1'b1;
    #20 din = 1'b0;
    repeat (10) @(posedge clk);
    #1 chk("glitch_dout", dout, 0);
    chk("glitch_busy", busy, 0);

    // Enable stall at cnt=2
    #1 din = 1'b1;
    repeat (4) @(posedge clk);
    #2 en = 1'b0;
    repeat (3) @(posedge clk);
    #2 en = 1'b1;
    @(posedge clk);
    #1 chk("stall_dout_1", dout, 0);
    chk("stall_busy_1", busy, 1);
    @(posedge clk);
    #1 chk("stall_dout_2", dout, 1);
    chk("stall_rise_2", rise, 1);

    #1 din = 1'b0;
    repeat (8) @(posedge clk);
    #1 chk("back_low_dout", dout, 0);

    // Reset mid-count at cnt=3, din held high
    #1 din = 1'b1;
    repeat (5) @(posedge clk);
    #3 chk("midrst_busy_before", busy, 1);
    rst_n = 1'b0;
    #1 chk("midrst_busy", busy, 0);
    chk("midrst_dout", dout, 0);
    chk("midrst_rise", rise, 0);
    #3 rst_n = 1'b1;
    e = 0;
    while (!dout && e < 20) begin
      @(posedge clk);
      #1 e++;
      if (!dout) chk("midrst_no_early_rise", rise, 0);
    end
    chk("midrst_latency_edges", e, 6);
    chk("midrst_rise", rise, 1);

    // Randomized bounce, enable gaps and occasional resets
    hold = 0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #2;
      if (hold == 0) begin
        din  = 1'($urandom_range(0, 1));
        hold = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 12));
      end
      hold--;
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        #4 rst_n = 1'b1;
      end
    end

    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/din_debouncer.md
DIN_DEBOUNCER -- requirements
Module: din_debouncer

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, meaning the number of consecutive sampled cycles a new input level must hold before it is accepted; legal range 1..255.
REQ-002 clk  input  1  meaning the single rising-edge clock for all state.
REQ-003 rst_n  input  1  meaning the asynchronous, active-low reset.
REQ-004 din  input  1  meaning the raw, asynchronous level input (switch or button).
REQ-005 en  input  1  meaning the debounce-count enable; when it is 0 the counter and FSM hold.
REQ-006 dout  output  1  meaning the registered, debounced level that drives the downstream d_ff d input.
REQ-007 rise  output  1  meaning a registered one-cycle pulse issued when dout goes 0->1.
REQ-008 fall  output  1  meaning a registered one-cycle pulse issued when dout goes 1->0.
REQ-009 busy  output  1  meaning high while the FSM is in a CHK state.
REQ-010 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.

Function
REQ-011 din SHALL pass through a 2-flop synchronizer (s1, s2) clocked on every clk edge regardless of en; only s2 is used downstream.
REQ-012 The FSM SHALL have four states: IDLE_LO (dout=0), CHK_HI, IDLE_HI (dout=1) and CHK_LO.
REQ-013 The counter width SHALL be 8 bits, and the counter SHALL saturate rather than wrap.
REQ-014 In IDLE_LO, on an edge with en=1 and s2=1: if STABLE_CYCLES=1, go to IDLE_HI; otherwise go to CHK_HI with cnt=1.
REQ-015 In CHK_HI, on an edge with en=1 and s2=1: cnt+1; when cnt+1 equals STABLE_CYCLES, go to IDLE_HI, set dout=1 and assert rise for exactly one cycle.
REQ-016 In CHK_HI, on an edge with en=1 and s2=0 (glitch): go back to IDLE_LO with cnt=0; dout does not change and no pulse is issued.
REQ-017 IDLE_HI and CHK_LO SHALL mirror REQ-014 to REQ-016 with the levels inverted; acceptance sets dout=0 and asserts fall.
REQ-018 When en=0 on an edge: the state, cnt and dout SHALL hold, and rise and fall SHALL be 0; counting resumes from the held cnt.
REQ-019 Latency with en=1 held: din settles before edge k -> dout, and its pulse, change after edge k+1+STABLE_CYCLES; for the default of 4, that is edge k+5.
REQ-020 rise and fall SHALL never both be high, and neither SHALL stay high longer than one cycle.
REQ-021 busy SHALL equal (state==CHK_HI || state==CHK_LO), decoded from registered state.
REQ-022 A din pulse shorter than STABLE_CYCLES synchronized cycles SHALL never change dout.
REQ-023 No combinational path SHALL exist from din or en to any output.

Reset
REQ-024 When rst_n=0, the block SHALL asynchronously set s1=0, s2=0, state=IDLE_LO, cnt=0, dout=0, rise=0, fall=0 and busy=0.
REQ-025 Reset asserted mid-CHK SHALL discard the count; after release, a held din=1 SHALL need the full 2+STABLE_CYCLES edges again.
REQ-026 On rst_n release with din=1, no rise SHALL be issued before the REQ-019 latency has elapsed.

Verification (STABLE_CYCLES=4, 10 ns clk, en=1 unless stated)
REQ-027 Clean rise: din 0->1 at 12 ns, before the edge at 15 ns -> dout=1 and rise=1 after the edge at 65 ns; rise=0 after 75 ns; busy high from the 35 ns edge to the 65 ns edge.
REQ-028 Glitch: din=1 for 20 ns (2 cycles) then 0 -> dout stays 0, rise never asserts, busy returns to 0.
REQ-029 Bounce: din toggles every 10 ns for 60 ns and then holds at 1 -> exactly one rise pulse, 5 edges after the last transition.
REQ-030 Enable stall: during CHK_HI with cnt=2, en=0 for 3 cycles -> cnt holds at 2; dout goes high 2 enabled edges after en returns to 1.
REQ-031 Falling path: starting from dout=1, din 1->0 -> dout=0 and fall=1 for one cycle at the same latency as REQ-027; rise stays 0.
REQ-032 Reset mid-count: rst_n=0 asynchronously while in CHK_HI with cnt=3 -> all outputs go to 0 immediately; after release, with din held at 1, dout rises 6 edges later.
